branch_redirect_ctrl: RTL



---
 rtl/branch_ctrl_pkg.sv | 21 ++
 rtl/branch_target_adder.sv | 23 ++
 rtl/branch_redirect_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared decode constants and FSM state encoding for the EX-stage redirect controller.
package branch_ctrl_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational control-flow target: pc + (imm<<1) for BRANCH/JAL, (rs1 + imm) & ~1 for JALR.
module branch_target_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] sum;

  always_comb begin
    base   = is_jalr ? ex_rs1 : ex_pc;
    offset = is_jalr ? ex_imm : {ex_imm[XLEN-2:0], 1'b0};
    sum    = base + offset;
    target = {sum[XLEN-1:1], sum[0] & ~is_jalr};
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/JAL/JALR resolver: registered PC redirect handshake plus wrong-path flush sequencing.
// Optional build macro MISALIGN_TRAP_EN turns targets with bit1 set into a trap pulse instead of a redirect.
//
// state    | meaning
// ST_IDLE  | waiting for a taken control-flow instruction in EX
// ST_REQ   | redirect_valid high, redirect_pc held until fetch_ready
// ST_FLUSH | redirect accepted, squashing IF/ID and ID/EX for FLUSH_CYCLES
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            zf,
  input  logic            cf,
  input  logic            vf,
  input  logic            sf,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_ready,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            busy,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
);

  state_t          state, state_d;
  logic [2:0]      cnt, cnt_d;
  logic            taken, accept, misaligned, issue;
  logic            rv_d, flush_d;
  logic            rv_q, flush_q;
  logic [XLEN-1:0] target, pc_q;

  branch_target_adder #(.XLEN(XLEN)) u_adder (
    .ex_pc   (ex_pc),
    .ex_rs1  (ex_rs1),
    .ex_imm  (ex_imm),
    .is_jalr (ex_opcode == OP_JALR),
    .target  (target)
  );

  always_comb begin
    taken = 1'b0;
    case (ex_opcode)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BRANCH: begin
        case (ex_funct3)
          F3_BEQ:  taken = zf;
          F3_BNE:  taken = ~zf;
          F3_BLT:  taken = sf ^ vf;
          F3_BGE:  taken = ~(sf ^ vf);
          F3_BLTU: taken = ~cf;
          F3_BGEU: taken = cf;
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  // Instructions arriving while busy are wrong-path and never sampled.
  assign accept = ex_valid & taken & (state == ST_IDLE);
`ifdef MISALIGN_TRAP_EN
  assign misaligned = target[1];
`else
  assign misaligned = 1'b0;
`endif
  assign issue = accept & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rv_q    <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rv_q    <= rv_d;
      flush_q <= flush_d;
      if (issue) pc_q <= target;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: if (issue) state_d = ST_REQ;
      ST_REQ: begin
        if (fetch_ready) begin
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (cnt == 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    rv_d    = (state_d == ST_REQ);
    flush_d = (state_d != ST_IDLE);
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign busy           = (state != ST_IDLE);

`ifdef MISALIGN_TRAP_EN
  logic            trap_q;
  logic [XLEN-1:0] trap_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q      <= accept & misaligned;
      trap_addr_q <= (accept & misaligned) ? target : '0;
    end
  end

  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`else
  assign misalign_trap = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule
